// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
// MDU_MADD_EN adds an op bit that selects the unsigned MADD/MSUB variant.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } op_e;

`ifdef MDU_MADD_EN
    localparam int OP_W = 4;
`else
    localparam int OP_W = 3;
`endif

    localparam int CNT_W = 4;

    function automatic logic op_unsigned(input logic [OP_W-1:0] op);
`ifdef MDU_MADD_EN
        if (op[2:1] == 2'b11) return op[3];
`endif
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit {hi,lo} result for mult/div (and MADD/MSUB
// under MDU_MADD_EN); divide by zero passes the current hi/lo through.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     rs,
    input  logic [31:0]     rt,
    input  logic [31:0]     hi,
    input  logic [31:0]     lo,
    output logic [63:0]     res
);

    logic        uns;
    logic [63:0] cur;
    logic [63:0] a64;
    logic [63:0] b64;
    logic [63:0] prod;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] qm;
    logic [31:0] rm;
    logic [31:0] q;
    logic [31:0] r;

    assign uns  = op_unsigned(op);
    assign cur  = {hi, lo};
    assign a64  = uns ? {32'b0, rs} : {{32{rs[31]}}, rs};
    assign b64  = uns ? {32'b0, rt} : {{32{rt[31]}}, rt};
    assign prod = a64 * b64;

    // One unsigned divider on magnitudes; signs are restored afterwards
    assign ma = (uns || !rs[31]) ? rs : -rs;
    assign mb = (uns || !rt[31]) ? rt : -rt;
    assign qm = ma / mb;
    assign rm = ma % mb;
    assign q  = (!uns && (rs[31] ^ rt[31])) ? -qm : qm;
    assign r  = (!uns && rs[31]) ? -rm : rm;

    always_comb begin
        res = cur;
        unique case (1'b1)
            op[2:1] == 2'b00: res = prod;
            op[2:1] == 2'b01: res = (rt == 32'd0) ? cur : {r, q};
`ifdef MDU_MADD_EN
            op[2:1] == 2'b11: res = op[0] ? cur - prod : cur + prod;
`endif
            default: res = cur;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: HI/LO registers plus a busy countdown.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     rs,
    input  logic [31:0]     rt,
    output logic            busy,
    output logic [31:0]     hi,
    output logic [31:0]     lo
);

    logic [CNT_W-1:0] cnt;
    logic [63:0]      pend;
    logic [63:0]      res;
    logic             acc;
    logic             is_mul;
    logic             is_div;
    logic             is_madd;
    logic             is_mthi;
    logic             is_mtlo;

    assign acc     = start & ~req & ~busy;
    assign is_mul  = (op[2:1] == 2'b00);
    assign is_div  = (op[2:1] == 2'b01);
    assign is_mthi = (op[2:0] == OP_MTHI);
    assign is_mtlo = (op[2:0] == OP_MTLO);
`ifdef MDU_MADD_EN
    assign is_madd = (op[2:1] == 2'b11);
`else
    assign is_madd = 1'b0;
`endif

    mdu_calc u_calc (
        .op  (op),
        .rs  (rs),
        .rt  (rt),
        .hi  (hi),
        .lo  (lo),
        .res (res)
    );

    // Result is latched at accept and only exposed when the count expires
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            busy <= 1'b0;
            pend <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (busy) begin
            if (cnt == CNT_W'(1)) begin
                {hi, lo} <= pend;
                cnt      <= '0;
                busy     <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (acc) begin
            unique case (1'b1)
                is_mthi: hi <= rs;
                is_mtlo: lo <= rs;
                is_mul | is_madd: begin
                    pend <= res;
                    cnt  <= CNT_W'(MULT_CYCLES);
                    busy <= 1'b1;
                end
                is_div: begin
                    pend <= res;
                    cnt  <= CNT_W'(DIV_CYCLES);
                    busy <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized self-checking bench for mdu_unit against a behavioural
// model of HI/LO, busy windows and arithmetic results.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            req;
    logic            start;
    logic [OP_W-1:0] op;
    logic [31:0]     rs;
    logic [31:0]     rt;
    logic            busy;
    logic [31:0]     hi;
    logic [31:0]     lo;

    int checks = 0;
    int passed = 0;
    bit chk_en = 0;

    // Model state: edge index, edge at which the pending op completes
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_pend = '0;
    int          edge_n = 0;
    int          done_n = 0;
    logic        m_busy = 1'b0;

    mdu_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_result(
        input logic [OP_W-1:0] o, input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        int unsigned     ua;
        int unsigned     ub;
        sp = longint'(int'(a)) * longint'(int'(b));
        up = 64'(a) * 64'(b);
        sa = a;
        sb = b;
        ua = a;
        ub = b;
        case (o[2:0])
            3'd0: return sp;
            3'd1: return up;
            3'd2: begin
                if (b == 0) return {h, l};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 0) return {h, l};
                return {32'(ua % ub), 32'(ua / ub)};
            end
`ifdef MDU_MADD_EN
            3'd6: return {h, l} + (o[3] ? up : sp);
            3'd7: return {h, l} - (o[3] ? up : sp);
`endif
            default: return {h, l};
        endcase
    endfunction

    task automatic model_edge();
        edge_n++;
        if (reset) begin
            m_hi   = '0;
            m_lo   = '0;
            m_pend = '0;
            done_n = edge_n;
        end else if (edge_n - 1 < done_n) begin
            if (edge_n == done_n) {m_hi, m_lo} = m_pend;
        end else if (start && !req) begin
            case (op[2:0])
                3'd0, 3'd1: begin
                    m_pend = ref_result(op, rs, rt, m_hi, m_lo);
                    done_n = edge_n + NM;
                end
                3'd2, 3'd3: begin
                    m_pend = ref_result(op, rs, rt, m_hi, m_lo);
                    done_n = edge_n + ND;
                end
                3'd4: m_hi = rs;
                3'd5: m_lo = rs;
`ifdef MDU_MADD_EN
                3'd6, 3'd7: begin
                    m_pend = ref_result(op, rs, rt, m_hi, m_lo);
                    done_n = edge_n + NM;
                end
`endif
                default: ;
            endcase
        end
        m_busy = (edge_n < done_n);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic step(input logic s, input logic [OP_W-1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic r, input logic rst);
        start = s;
        op    = o;
        rs    = a;
        rt    = b;
        req   = r;
        reset = rst;
        @(posedge clk);
        model_edge();
        chk_en = 1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, 0);
    endtask

    task automatic issue_count(input logic [OP_W-1:0] o,
                               input logic [31:0] a, input logic [31:0] b,
                               output int n);
        step(1, o, a, b, 0, 0);
        n = busy;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            n += busy;
        end
    endtask

    int bc;

    initial begin
        step(0, '0, '0, '0, 0, 1);
        step(0, '0, '0, '0, 0, 1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        issue_count(OP_W'(OP_MULT), 32'hFFFF_FFFE, 32'd3, bc);
        chk("mult_busy_len", bc, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        issue_count(OP_W'(OP_DIVU), 32'd100, 32'd7, bc);
        chk("divu_busy_len", bc, 32'd10);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        issue_count(OP_W'(OP_DIV), 32'hFFFF_FFF9, 32'd2, bc);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        step(1, OP_W'(OP_MTHI), 32'h11, '0, 0, 0);
        step(1, OP_W'(OP_MTLO), 32'h22, '0, 0, 0);
        chk("mt_busy", {31'b0, busy}, 32'd0);
        issue_count(OP_W'(OP_DIV), 32'd50, 32'd0, bc);
        chk("div0_busy_len", bc, 32'd10);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        step(1, OP_W'(OP_MULT), 32'd6, 32'd7, 1, 0);
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_hi", hi, 32'h11);
        step(1, OP_W'(OP_MULT), 32'd6, 32'd7, 0, 0);
        step(0, '0, '0, '0, 1, 0);
        idle(5);
        chk("req_mid_lo", lo, 32'd42);
        chk("req_mid_hi", hi, 32'd0);

        step(1, OP_W'(OP_MTHI), 32'hDEAD_BEEF, '0, 0, 0);
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_busy", {31'b0, busy}, 32'd0);

        step(1, OP_W'(OP_MULTU), 32'd3, 32'd4, 0, 0);
        step(1, OP_W'(OP_MULTU), 32'd100, 32'd100, 0, 0);
        idle(6);
        chk("ign_busy_lo", lo, 32'd12);

        step(1, OP_W'(OP_DIVU), 32'd1000, 32'd3, 0, 0);
        idle(3);
        step(0, '0, '0, '0, 0, 1);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);

`ifdef MDU_MADD_EN
        step(1, OP_W'(OP_MTLO), 32'd5, '0, 0, 0);
        step(1, OP_W'(OP_MADD), 32'd2, 32'd3, 0, 0);
        idle(6);
        chk("madd_lo", lo, 32'd11);
        chk("madd_hi", hi, 32'd0);
`endif

        for (int i = 0; i < 2000; i++) begin
            logic [OP_W-1:0] o;
            logic [31:0]     a;
            logic [31:0]     b;
            o = OP_W'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40))
                                            : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0
              : ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9))
              : $urandom;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            step($urandom_range(0, 2) == 0, o, a, b,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
        end
        idle(12);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
